dds_phase_gen: RTL and testbench
================================

Name: dds_phase_gen

Overview:
- AXI-Stream master that generates the 48-bit DDS phase stream consumed by the BRAM address slicing stage.
- Holds a phase accumulator advanced by a programmable frequency word. Each beat carries accumulator plus phase offset, mod 2^48.
- Honours tready backpressure: the phase advances only on accepted beats, so the downstream table address never skips.

Parameters:
- PHASE_WIDTH, 48, accumulator and tdata width; the modulus is 2^PHASE_WIDTH.
- COUNT_WIDTH, 32, width of the beat counter.

Ports:
- clk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- enable  in  1  level; run request
- cfg_wr  in  1  one-cycle strobe; latches freq_word and phase_offset
- freq_word  in  PHASE_WIDTH  phase increment per accepted beat
- phase_offset  in  PHASE_WIDTH  constant added to accumulator on output
- sync  in  1  one-cycle strobe; restarts accumulator at 0
- m_axis_tdata_phase  out  PHASE_WIDTH  phase beat (acc + offset)
- m_axis_tvalid_phase  out  1  beat valid
- m_axis_tready_phase  in  1  downstream ready
- wrap_pulse  out  1  one-cycle pulse: accumulator carried out of MSB
- beat_count  out  COUNT_WIDTH  accepted beats since last LOAD/sync
- busy  out  1  high in LOAD, RUN, DRAIN

Behaviour:
- Reset (aresetn=0 at a clk edge):
  - Clears acc, freq_reg, off_reg, tdata, tvalid, wrap_pulse and beat_count to 0; state=IDLE.
  - Takes effect on the next edge even mid-beat, i.e. tvalid drops without a handshake.
- Config:
  - cfg_wr loads freq_reg and off_reg on the next edge, in any state.
  - If cfg_wr coincides with a transfer, that update uses the old values; the new values apply from the next update.
- Transfer: xfer = tvalid & tready.
- States:
  - IDLE: tvalid=0, busy=0. enable=1 -> LOAD.
  - LOAD: acc<=0; tdata<=off_reg; beat_count<=0. Next state is RUN with tvalid=1. First beat appears 2 cycles after enable is sampled high.
  - RUN, on xfer:
    - sum = acc + freq_reg (PHASE_WIDTH+1 bits).
    - acc <= sum[PHASE_WIDTH-1:0]; tdata <= acc_next + off_reg, truncated.
    - wrap_pulse <= sum[PHASE_WIDTH]; beat_count <= beat_count+1, wrapping at 2^COUNT_WIDTH.
  - RUN, no xfer: tdata and tvalid held stable (AXIS rule); wrap_pulse <= 0.
  - RUN, enable=0: -> DRAIN, or straight to IDLE if xfer happens in the same cycle.
  - DRAIN: tvalid held until xfer; on xfer tvalid<=0 and -> IDLE. No accumulator update and no wrap_pulse in DRAIN.
  - If enable re-asserts in DRAIN, the block still completes DRAIN -> IDLE -> LOAD.
- sync (honoured in RUN only; ignored in IDLE, LOAD, DRAIN):
  - acc<=0; tdata<=off_reg; beat_count<=0; wrap_pulse<=0.
  - If a beat is pending unaccepted, sync replaces its tdata anyway. This is the only permitted mid-beat data change and is documented for the downstream sync domain.
  - sync coincident with xfer: sync wins; the next beat is off_reg and beat_count=0 (not 1).
- wrap_pulse:
  - Registered; asserts the same cycle the new tdata appears.
  - freq_word=0 never wraps.
  - freq_word=2^48-1 wraps on every beat except the first advance from acc=0.
- Offset: added mod 2^PHASE_WIDTH; it never affects wrap_pulse.
- Throughput: with tready=1 continuously, one beat per clk.

Test Plan:
- Reset then enable=1, cfg freq=0x0000_0100_0000, off=0, tready=1.
  - tvalid rises 2 cycles after enable.
  - Beats are 0, 0x0100_0000, 0x0200_0000, ...
  - beat_count increments each cycle.
- Backpressure:
  - Setup: freq=1, tready pattern 1,0,0,1,1.
  - Beats are 0,1,1,1,2,...; tdata stable while tready=0.
  - beat_count advances only on xfer.
- Wrap:
  - Setup: freq=0x8000_0000_0000, off=0x1.
  - Beats are 0x1, 0x8000_0000_0001, 0x1, ...
  - wrap_pulse high coincident with every third-and-later beat pattern, i.e. each return to 0x1 after the first.
  - off=0xFFFF_FFFF_FFFF with acc=1 gives tdata=0, no wrap_pulse.
- sync mid-run with xfer:
  - Setup: freq=5, sync coincident with xfer at acc=20.
  - Next beat = off_reg, beat_count=0; following beat = 5+off.
- Disable with tready=0:
  - tvalid stays high in DRAIN until tready=1 for one cycle, then 0.
  - Accumulator is unchanged; a subsequent enable restarts at off_reg.
- cfg_wr coincident with xfer (freq 3 -> 7):
  - The update in that cycle uses 3; later updates use 7.
  - aresetn=0 mid-beat: tvalid=0 and all outputs 0 the next cycle.

Source files
------------

// File: rtl/dds_phase_gen.sv
// AXI-Stream phase source for a DDS: accumulator advanced by a programmable frequency word,
// output beat = accumulator + phase offset (mod 2^PHASE_WIDTH), advancing only on accepted beats.
module dds_phase_gen #(
   parameter int PHASE_WIDTH = 48,
   parameter int COUNT_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   aresetn,
   input  logic                   enable,
   input  logic                   cfg_wr,
   input  logic [PHASE_WIDTH-1:0] freq_word,
   input  logic [PHASE_WIDTH-1:0] phase_offset,
   input  logic                   sync,
   output logic [PHASE_WIDTH-1:0] m_axis_tdata_phase,
   output logic                   m_axis_tvalid_phase,
   input  logic                   m_axis_tready_phase,
   output logic                   wrap_pulse,
   output logic [COUNT_WIDTH-1:0] beat_count,
   output logic                   busy
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   logic [1:0]             state_reg,  state_next;
   logic [PHASE_WIDTH-1:0] acc_reg,    acc_next;
   logic [PHASE_WIDTH-1:0] freq_reg;
   logic [PHASE_WIDTH-1:0] off_reg;
   logic [PHASE_WIDTH-1:0] tdata_reg,  tdata_next;
   logic                   tvalid_reg, tvalid_next;
   logic                   wrap_reg,   wrap_next;
   logic [COUNT_WIDTH-1:0] count_reg,  count_next;

   logic                   xfer;
   logic [PHASE_WIDTH:0]   sum;

   assign xfer = tvalid_reg & m_axis_tready_phase;
   // One extra bit so the carry out of the accumulator MSB becomes the wrap flag.
   assign sum  = {1'b0, acc_reg} + {1'b0, freq_reg};

   always_comb begin
      state_next  = state_reg;
      acc_next    = acc_reg;
      tdata_next  = tdata_reg;
      tvalid_next = tvalid_reg;
      wrap_next   = 1'b0;
      count_next  = count_reg;

      case (state_reg)
         ST_IDLE: begin
            tvalid_next = 1'b0;
            if (enable) begin
               state_next = ST_LOAD;
            end
         end

         ST_LOAD: begin
            acc_next    = '0;
            tdata_next  = off_reg;
            count_next  = '0;
            tvalid_next = 1'b1;
            state_next  = ST_RUN;
         end

         ST_RUN: begin
            // sync outranks an accepted beat: the stream restarts at the offset with count 0.
            if (sync) begin
               acc_next   = '0;
               tdata_next = off_reg;
               count_next = '0;
            end else if (xfer) begin
               count_next = count_reg + COUNT_WIDTH'(1);
               if (enable) begin
                  acc_next   = sum[PHASE_WIDTH-1:0];
                  tdata_next = sum[PHASE_WIDTH-1:0] + off_reg;
                  wrap_next  = sum[PHASE_WIDTH];
               end
            end
            if (!enable) begin
               if (xfer) begin
                  tvalid_next = 1'b0;
                  state_next  = ST_IDLE;
               end else begin
                  state_next  = ST_DRAIN;
               end
            end
         end

         ST_DRAIN: begin
            if (xfer) begin
               tvalid_next = 1'b0;
               count_next  = count_reg + COUNT_WIDTH'(1);
               state_next  = ST_IDLE;
            end
         end

         default: begin
            tvalid_next = 1'b0;
            state_next  = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!aresetn) begin
         state_reg  <= ST_IDLE;
         acc_reg    <= '0;
         freq_reg   <= '0;
         off_reg    <= '0;
         tdata_reg  <= '0;
         tvalid_reg <= 1'b0;
         wrap_reg   <= 1'b0;
         count_reg  <= '0;
      end else begin
         state_reg  <= state_next;
         acc_reg    <= acc_next;
         tdata_reg  <= tdata_next;
         tvalid_reg <= tvalid_next;
         wrap_reg   <= wrap_next;
         count_reg  <= count_next;
         if (cfg_wr) begin
            freq_reg <= freq_word;
            off_reg  <= phase_offset;
         end
      end
   end

   assign m_axis_tdata_phase  = tdata_reg;
   assign m_axis_tvalid_phase = tvalid_reg;
   assign wrap_pulse          = wrap_reg;
   assign beat_count          = count_reg;
   assign busy                = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_dds_phase_gen.sv
// Scoreboarded bench for dds_phase_gen: directed runs push expected beats, a negedge monitor pops on handshake.
module tb_dds_phase_gen;

   logic        clk = 1'b0;
   logic        aresetn;
   logic        enable;
   logic        cfg_wr;
   logic [47:0] freq_word;
   logic [47:0] phase_offset;
   logic        sync;
   logic [47:0] tdata;
   logic        tvalid;
   logic        tready;
   logic        wrap_pulse;
   logic [31:0] beat_count;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct packed {
      logic [47:0] data;
      logic        wrap;
      logic [31:0] cnt;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   dds_phase_gen #(.PHASE_WIDTH(48), .COUNT_WIDTH(32)) dut (
      .clk                 (clk),
      .aresetn             (aresetn),
      .enable              (enable),
      .cfg_wr              (cfg_wr),
      .freq_word           (freq_word),
      .phase_offset        (phase_offset),
      .sync                (sync),
      .m_axis_tdata_phase  (tdata),
      .m_axis_tvalid_phase (tvalid),
      .m_axis_tready_phase (tready),
      .wrap_pulse          (wrap_pulse),
      .beat_count          (beat_count),
      .busy                (busy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic push(input logic [47:0] d, input logic w, input logic [31:0] c);
      exp_t e;
      e.data = d;
      e.wrap = w;
      e.cnt  = c;
      exp_q.push_back(e);
   endtask

   // Monitor: every accepted beat is compared against the head of the scoreboard.
   always @(negedge clk) begin
      if (tvalid && tready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_beat: got tdata=0x%0h count=%0d, expected no beat", tdata, beat_count);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            $display("beat tdata=0x%012h wrap=%0b count=%0d (exp 0x%012h %0b %0d)",
                     tdata, wrap_pulse, beat_count, e.data, e.wrap, e.cnt);
            check("beat_tdata", 64'(tdata), 64'(e.data));
            check("beat_wrap", 64'(wrap_pulse), 64'(e.wrap));
            check("beat_count", 64'(beat_count), 64'(e.cnt));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic [47:0] f, input logic [47:0] o);
      freq_word    = f;
      phase_offset = o;
      cfg_wr       = 1'b1;
      step();
      cfg_wr       = 1'b0;
   endtask

   // Raise enable from IDLE; the first beat must be valid exactly two edges later.
   task automatic start_run();
      enable = 1'b1;
      step();
      check("load_tvalid_low", 64'(tvalid), 64'd0);
      check("load_busy", 64'(busy), 64'd1);
      step();
      check("first_beat_tvalid", 64'(tvalid), 64'd1);
   endtask

   // Drive tready from a repeating pattern until n beats have been handed over.
   task automatic run_beats(input int n, input logic [7:0] pat, input int plen);
      int got = 0;
      int cyc = 0;
      int i   = 0;
      while (got < n && cyc < 200) begin
         tready = pat[i % plen];
         i++;
         if (tvalid && tready) got++;
         step();
         cyc++;
      end
      tready = 1'b0;
      if (got < n) begin
         n_checks++;
         n_errors++;
         $display("FAIL run_timeout: got %0d beats, expected %0d", got, n);
      end
   endtask

   // Reset lands while a beat is still pending; everything must clear on the next edge.
   task automatic finish_test(input string name);
      check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      enable  = 1'b0;
      aresetn = 1'b0;
      step();
      check("rst_tvalid", 64'(tvalid), 64'd0);
      check("rst_tdata", 64'(tdata), 64'd0);
      check("rst_wrap", 64'(wrap_pulse), 64'd0);
      check("rst_count", 64'(beat_count), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      aresetn = 1'b1;
      step();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      aresetn      = 1'b0;
      enable       = 1'b0;
      cfg_wr       = 1'b0;
      freq_word    = '0;
      phase_offset = '0;
      sync         = 1'b0;
      tready       = 1'b0;
      step();
      step();
      check("init_tvalid", 64'(tvalid), 64'd0);
      check("init_tdata", 64'(tdata), 64'd0);
      check("init_count", 64'(beat_count), 64'd0);
      check("init_busy", 64'(busy), 64'd0);
      aresetn = 1'b1;
      step();

      // Basic ramp, one beat per clock
      cfg(48'h0000_0100_0000, 48'h0);
      for (int k = 0; k < 8; k++) push(48'(k) * 48'h0000_0100_0000, 1'b0, 32'(k));
      start_run();
      run_beats(8, 8'hFF, 1);
      finish_test("ramp");

      // Backpressure 1,0,0,1,1
      cfg(48'h1, 48'h0);
      for (int k = 0; k < 6; k++) push(48'(k), 1'b0, 32'(k));
      start_run();
      run_beats(6, 8'b0001_1001, 5);
      finish_test("backpressure");

      // Half-circle increment wraps every second advance
      cfg(48'h8000_0000_0000, 48'h1);
      push(48'h0000_0000_0001, 1'b0, 32'd0);
      push(48'h8000_0000_0001, 1'b0, 32'd1);
      push(48'h0000_0000_0001, 1'b1, 32'd2);
      push(48'h8000_0000_0001, 1'b0, 32'd3);
      push(48'h0000_0000_0001, 1'b1, 32'd4);
      start_run();
      run_beats(5, 8'hFF, 1);
      finish_test("wrap_half");

      // Offset wrap-around never raises wrap_pulse
      cfg(48'h1, 48'hFFFF_FFFF_FFFF);
      push(48'hFFFF_FFFF_FFFF, 1'b0, 32'd0);
      push(48'h0000_0000_0000, 1'b0, 32'd1);
      push(48'h0000_0000_0001, 1'b0, 32'd2);
      start_run();
      run_beats(3, 8'hFF, 1);
      finish_test("offset_wrap");

      // Maximum increment wraps on every advance except the first
      cfg(48'hFFFF_FFFF_FFFF, 48'h0);
      push(48'h0000_0000_0000, 1'b0, 32'd0);
      push(48'hFFFF_FFFF_FFFF, 1'b0, 32'd1);
      push(48'hFFFF_FFFF_FFFE, 1'b1, 32'd2);
      push(48'hFFFF_FFFF_FFFD, 1'b1, 32'd3);
      start_run();
      run_beats(4, 8'hFF, 1);
      finish_test("freq_max");

      // sync coincident with handshake at acc=20, then sync on a pending beat
      cfg(48'h5, 48'h10);
      push(48'h10, 1'b0, 32'd0);
      push(48'h15, 1'b0, 32'd1);
      push(48'h1A, 1'b0, 32'd2);
      push(48'h1F, 1'b0, 32'd3);
      push(48'h24, 1'b0, 32'd4);
      push(48'h10, 1'b0, 32'd0);
      push(48'h15, 1'b0, 32'd1);
      push(48'h1A, 1'b0, 32'd2);
      start_run();
      run_beats(4, 8'hFF, 1);
      tready = 1'b1;
      sync   = 1'b1;
      step();
      sync   = 1'b0;
      tready = 1'b0;
      check("sync_xfer_tdata", 64'(tdata), 64'h10);
      check("sync_xfer_count", 64'(beat_count), 64'd0);
      run_beats(3, 8'hFF, 1);
      sync = 1'b1;
      step();
      sync = 1'b0;
      check("sync_pending_tdata", 64'(tdata), 64'h10);
      check("sync_pending_count", 64'(beat_count), 64'd0);
      check("sync_pending_tvalid", 64'(tvalid), 64'd1);
      finish_test("sync");

      // Disable under backpressure drains the pending beat, then restarts at offset
      cfg(48'h2, 48'h100);
      push(48'h100, 1'b0, 32'd0);
      push(48'h102, 1'b0, 32'd1);
      push(48'h104, 1'b0, 32'd2);
      start_run();
      run_beats(3, 8'hFF, 1);
      enable = 1'b0;
      step();
      check("drain_tvalid", 64'(tvalid), 64'd1);
      check("drain_busy", 64'(busy), 64'd1);
      check("drain_tdata", 64'(tdata), 64'h106);
      step();
      check("drain_hold_tvalid", 64'(tvalid), 64'd1);
      check("drain_hold_tdata", 64'(tdata), 64'h106);
      push(48'h106, 1'b0, 32'd3);
      tready = 1'b1;
      step();
      tready = 1'b0;
      check("drain_done_tvalid", 64'(tvalid), 64'd0);
      check("drain_done_busy", 64'(busy), 64'd0);
      push(48'h100, 1'b0, 32'd0);
      push(48'h102, 1'b0, 32'd1);
      start_run();
      run_beats(2, 8'hFF, 1);
      finish_test("drain");

      // cfg_wr coincident with handshake: that advance still uses the old increment
      cfg(48'h3, 48'h0);
      push(48'd0, 1'b0, 32'd0);
      push(48'd3, 1'b0, 32'd1);
      push(48'd6, 1'b0, 32'd2);
      push(48'd9, 1'b0, 32'd3);
      push(48'd16, 1'b0, 32'd4);
      start_run();
      run_beats(2, 8'hFF, 1);
      freq_word = 48'h7;
      cfg_wr    = 1'b1;
      tready    = 1'b1;
      step();
      cfg_wr    = 1'b0;
      tready    = 1'b0;
      check("cfg_xfer_tdata", 64'(tdata), 64'd9);
      run_beats(2, 8'hFF, 1);
      finish_test("cfg_xfer");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
